tcb_cmn_gpio_irq: RTL and testbench

- GPIO input event controller on a TCB common RW channel; subordinate.
- Synchronizes and debounces GPIO inputs, then detects rising/falling edges.
- Latches enabled edges into sticky W1C status bits and drives a level interrupt to the system interrupt controller.
- Sits beside the GPIO output controller on the peripheral bus.

---
 rtl/tcb_cmn_gpio_irq.sv | 170 +++++++++++++++++
 tb/tb_tcb_cmn_gpio_irq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcb_cmn_gpio_irq.sv
// GPIO input event controller: sync, debounce, edge detect, sticky W1C status
// and a registered level interrupt, exposed as a TCB subordinate (DLY=0).
module tcb_cmn_gpio_irq #(
  parameter int unsigned GW      = 32,
  parameter int unsigned CFG_CDC = 2,
  parameter int unsigned DBW_CNT = 16,
  parameter int unsigned PHY_DLY = 0,
  parameter int unsigned PHY_DBW = 32
) (
  input  logic          tcb_clk_i,
  input  logic          tcb_rst_i,
  input  logic          tcb_vld_i,
  output logic          tcb_rdy_o,
  input  logic          tcb_req_wen_i,
  input  logic [31:0]   tcb_req_adr_i,
  input  logic [3:0]    tcb_req_ben_i,
  input  logic [31:0]   tcb_req_wdt_i,
  output logic [31:0]   tcb_rsp_rdt_o,
  output logic [1:0]    tcb_rsp_sts_o,
  input  logic [GW-1:0] gpio_i,
  output logic          irq_o
);

  if (PHY_DLY != 0) begin : g_err_dly
    $error("tcb_cmn_gpio_irq: PHY_DLY must be 0");
  end
  if (PHY_DBW != 32) begin : g_err_dbw
    $error("tcb_cmn_gpio_irq: PHY_DBW must be 32");
  end
  if (GW < 1 || GW > 32) begin : g_err_gw
    $error("tcb_cmn_gpio_irq: GW must be 1..32");
  end
  if (CFG_CDC == 1) begin : g_err_cdc
    $error("tcb_cmn_gpio_irq: CFG_CDC must be 0 or >=2");
  end
  if (DBW_CNT < 1 || DBW_CNT > 32) begin : g_err_cnt
    $error("tcb_cmn_gpio_irq: DBW_CNT must be 1..32");
  end

  localparam logic [4:0] ADR_IN       = 5'h00;
  localparam logic [4:0] ADR_RISE_EN  = 5'h04;
  localparam logic [4:0] ADR_FALL_EN  = 5'h08;
  localparam logic [4:0] ADR_STATUS   = 5'h0C;
  localparam logic [4:0] ADR_IRQ_EN   = 5'h10;
  localparam logic [4:0] ADR_DEBOUNCE = 5'h14;
  localparam logic [4:0] ADR_RAW      = 5'h18;

  logic [GW-1:0]      syn;
  logic [GW-1:0]      rise_en_q, rise_en_d;
  logic [GW-1:0]      fall_en_q, fall_en_d;
  logic [GW-1:0]      irq_en_q, irq_en_d;
  logic [GW-1:0]      sts_q, sts_d;
  logic [GW-1:0]      smp_q, smp_d;
  logic [GW-1:0]      deb_q, deb_d;
  logic [GW-1:0]      dly_q;
  logic [DBW_CNT-1:0] per_q, per_d;
  logic [DBW_CNT-1:0] cnt_q, cnt_d;
  logic               irq_q, irq_d;

  logic [4:0]    adr;
  logic          wr_en;
  logic          tick;
  logic [GW-1:0] stable;
  logic [GW-1:0] evt;
  logic [GW-1:0] clr;
  logic          unused_bus;

  assign adr        = tcb_req_adr_i[4:0];
  assign wr_en      = tcb_vld_i & tcb_req_wen_i;
  assign unused_bus = ^{tcb_req_adr_i[31:5], tcb_req_ben_i, tcb_req_wdt_i};

  if (CFG_CDC == 0) begin : g_cdc_byp
    assign syn = gpio_i;
  end else begin : g_cdc
    logic [GW-1:0] sync_q [CFG_CDC];
    always_ff @(posedge tcb_clk_i or posedge tcb_rst_i) begin
      if (tcb_rst_i) begin
        for (int unsigned i = 0; i < CFG_CDC; i++) sync_q[i] <= '0;
      end else begin
        sync_q[0] <= gpio_i;
        for (int unsigned i = 1; i < CFG_CDC; i++) sync_q[i] <= sync_q[i-1];
      end
    end
    assign syn = sync_q[CFG_CDC-1];
  end

  assign tick   = (per_q != '0) && (cnt_q == per_q);
  assign stable = ~(syn ^ smp_q);
  assign evt    = (deb_q & ~dly_q & rise_en_q) | (~deb_q & dly_q & fall_en_q);
  assign clr    = (wr_en && adr == ADR_STATUS) ? tcb_req_wdt_i[GW-1:0] : '0;

  always_comb begin
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    irq_en_d  = irq_en_q;
    per_d     = per_q;
    cnt_d     = cnt_q + DBW_CNT'(1);
    smp_d     = smp_q;
    deb_d     = deb_q;
    // A bit only follows syn once two consecutive ticks agree on its value.
    if (per_q == '0) begin
      deb_d = syn;
      cnt_d = '0;
    end else if (tick) begin
      smp_d = syn;
      deb_d = (syn & stable) | (deb_q & ~stable);
      cnt_d = '0;
    end
    // Set after clear so an event colliding with W1C keeps the bit.
    sts_d = (sts_q & ~clr) | evt;
    irq_d = |(sts_q & irq_en_q);
    if (wr_en) begin
      case (adr)
        ADR_RISE_EN:  rise_en_d = tcb_req_wdt_i[GW-1:0];
        ADR_FALL_EN:  fall_en_d = tcb_req_wdt_i[GW-1:0];
        ADR_IRQ_EN:   irq_en_d  = tcb_req_wdt_i[GW-1:0];
        ADR_DEBOUNCE: begin
          per_d = tcb_req_wdt_i[DBW_CNT-1:0];
          cnt_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge tcb_clk_i or posedge tcb_rst_i) begin
    if (tcb_rst_i) begin
      rise_en_q <= '0;
      fall_en_q <= '0;
      irq_en_q  <= '0;
      sts_q     <= '0;
      smp_q     <= '0;
      deb_q     <= '0;
      dly_q     <= '0;
      per_q     <= '0;
      cnt_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      irq_en_q  <= irq_en_d;
      sts_q     <= sts_d;
      smp_q     <= smp_d;
      deb_q     <= deb_d;
      dly_q     <= deb_q;
      per_q     <= per_d;
      cnt_q     <= cnt_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    tcb_rsp_rdt_o = '0;
    case (adr)
      ADR_IN:       tcb_rsp_rdt_o = 32'(deb_q);
      ADR_RISE_EN:  tcb_rsp_rdt_o = 32'(rise_en_q);
      ADR_FALL_EN:  tcb_rsp_rdt_o = 32'(fall_en_q);
      ADR_STATUS:   tcb_rsp_rdt_o = 32'(sts_q);
      ADR_IRQ_EN:   tcb_rsp_rdt_o = 32'(irq_en_q);
      ADR_DEBOUNCE: tcb_rsp_rdt_o = 32'(per_q);
      ADR_RAW:      tcb_rsp_rdt_o = 32'(syn);
      default:      tcb_rsp_rdt_o = '0;
    endcase
  end

  assign tcb_rdy_o     = 1'b1;
  assign tcb_rsp_sts_o = '0;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_tcb_cmn_gpio_irq.sv
// Directed bench for tcb_cmn_gpio_irq: stimulus pushes expected read data and
// irq levels into queues; a negedge monitor pops and compares.
module tb_tcb_cmn_gpio_irq;

  localparam logic [4:0] A_IN   = 5'h00;
  localparam logic [4:0] A_RISE = 5'h04;
  localparam logic [4:0] A_FALL = 5'h08;
  localparam logic [4:0] A_STS  = 5'h0C;
  localparam logic [4:0] A_IRQE = 5'h10;
  localparam logic [4:0] A_DEB  = 5'h14;
  localparam logic [4:0] A_RAW  = 5'h18;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t rd_q[$];
  exp_t irq_q[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic        wen = 1'b0;
  logic        sel1 = 1'b0;
  logic        irq_chk = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] wdt = '0;
  logic [3:0]  ben = '1;
  logic [31:0] gpio = '0;
  logic [7:0]  gpio8 = '0;

  logic        rdy0, rdy1, irq0, irq1;
  logic [31:0] rdt0, rdt1;
  logic [1:0]  sts0, sts1;
  logic        vld0, vld1;

  int nvec = 0;
  int nerr = 0;

  assign vld0 = vld & ~sel1;
  assign vld1 = vld & sel1;

  always #5 clk = ~clk;

  tcb_cmn_gpio_irq #(.GW(32), .CFG_CDC(2), .DBW_CNT(16)) dut0 (
    .tcb_clk_i(clk), .tcb_rst_i(rst), .tcb_vld_i(vld0), .tcb_rdy_o(rdy0),
    .tcb_req_wen_i(wen), .tcb_req_adr_i(adr), .tcb_req_ben_i(ben),
    .tcb_req_wdt_i(wdt), .tcb_rsp_rdt_o(rdt0), .tcb_rsp_sts_o(sts0),
    .gpio_i(gpio), .irq_o(irq0)
  );

  tcb_cmn_gpio_irq #(.GW(8), .CFG_CDC(0), .DBW_CNT(8)) dut1 (
    .tcb_clk_i(clk), .tcb_rst_i(rst), .tcb_vld_i(vld1), .tcb_rdy_o(rdy1),
    .tcb_req_wen_i(wen), .tcb_req_adr_i(adr), .tcb_req_ben_i(ben),
    .tcb_req_wdt_i(wdt), .tcb_rsp_rdt_o(rdt1), .tcb_rsp_sts_o(sts1),
    .gpio_i(gpio8), .irq_o(irq1)
  );

  // Monitor: compares whenever a read is presented or an irq check is flagged.
  always @(negedge clk) begin
    logic [31:0] rdt_m;
    logic        rdy_m, irq_m;
    logic [1:0]  sts_m;
    exp_t        e;
    rdt_m = sel1 ? rdt1 : rdt0;
    rdy_m = sel1 ? rdy1 : rdy0;
    sts_m = sel1 ? sts1 : sts0;
    irq_m = sel1 ? irq1 : irq0;
    if (vld && !wen) begin
      nvec++;
      if (rd_q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_read: adr=%h rdt=%h, no expectation queued", adr, rdt_m);
      end else begin
        e = rd_q.pop_front();
        if (rdt_m !== e.val) begin
          nerr++;
          $display("FAIL %s: rdt=%h expected=%h", e.name, rdt_m, e.val);
        end
      end
      nvec++;
      if ({rdy_m, sts_m} !== 3'b100) begin
        nerr++;
        $display("FAIL rdy_sts: rdy=%b sts=%b expected rdy=1 sts=00", rdy_m, sts_m);
      end
    end
    if (irq_chk) begin
      nvec++;
      if (irq_q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_irq_check: irq=%b, no expectation queued", irq_m);
      end else begin
        e = irq_q.pop_front();
        if (irq_m !== e.val[0]) begin
          nerr++;
          $display("FAIL %s_irq: irq=%b expected=%b", e.name, irq_m, e.val[0]);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    adr = 32'(a);
    wdt = d;
    vld = 1'b1;
    wen = 1'b1;
    step(1);
    vld = 1'b0;
    wen = 1'b0;
  endtask

  // ie < 0 skips the irq check for this read.
  task automatic rdi(input logic [4:0] a, input logic [31:0] e, input int ie, input string nm);
    exp_t x;
    x.name = nm;
    x.val  = e;
    rd_q.push_back(x);
    if (ie >= 0) begin
      x.val = 32'(ie);
      irq_q.push_back(x);
      irq_chk = 1'b1;
    end
    adr = 32'(a);
    vld = 1'b1;
    wen = 1'b0;
    step(1);
    vld = 1'b0;
    irq_chk = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e, input string nm);
    rdi(a, e, -1, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step(2);
    rst = 1'b0;
    step(1);

    // Power-on reset values
    rdi(A_IN,   32'h0, 0, "por_in");
    rd(A_RISE,  32'h0, "por_rise");
    rd(A_FALL,  32'h0, "por_fall");
    rd(A_STS,   32'h0, "por_sts");
    rd(A_IRQE,  32'h0, "por_irqen");
    rd(A_DEB,   32'h0, "por_deb");
    rd(A_RAW,   32'h0, "por_raw");

    // Rise edge path, PER=0, two sync stages
    wr(A_RISE, 32'h1);
    wr(A_IRQE, 32'h1);
    gpio[0] = 1'b1;
    step(2);
    rdi(A_IN,  32'h0, 0, "rise_in_c2");
    rdi(A_IN,  32'h1, 0, "rise_in_c3");
    rdi(A_STS, 32'h1, 0, "rise_sts_c4");
    rdi(A_STS, 32'h1, 1, "rise_irq_c5");
    wr(A_STS, 32'h1);
    rdi(A_STS, 32'h0, 1, "w1c_sts");
    rdi(A_STS, 32'h0, 0, "w1c_irq");

    // Fall edge with interrupt masked, then unmasked
    gpio[1] = 1'b1;
    step(6);
    wr(A_FALL, 32'h2);
    wr(A_IRQE, 32'h0);
    rd(A_STS, 32'h0, "fall_pre");
    gpio[1] = 1'b0;
    step(6);
    rdi(A_STS, 32'h2, 0, "fall_masked");
    rd(A_IN, 32'h1, "fall_in");
    wr(A_IRQE, 32'h2);
    rdi(A_IRQE, 32'h2, 0, "unmask_lag");
    rdi(A_STS,  32'h2, 1, "unmask");
    wr(A_STS, 32'h2);
    wr(A_IRQE, 32'h0);
    step(2);
    rdi(A_STS, 32'h0, 0, "fall_clr");

    // Debounce, PER=9 -> tick every 10 cycles
    wr(A_DEB, 32'd9);
    rd(A_DEB, 32'd9, "deb_rd");
    gpio[2] = 1'b1;
    step(5);
    gpio[2] = 1'b0;
    step(40);
    rd(A_IN,  32'h1, "glitch_in");
    rd(A_RAW, 32'h1, "glitch_raw");
    gpio[2] = 1'b1;
    step(12);
    rd(A_IN, 32'h1, "deb_early");
    step(9);
    rd(A_IN, 32'h5, "deb_hold");
    wr(A_DEB, 32'h0);

    // Event on bit 3 collides with W1C of bit 3
    wr(A_STS, 32'hFFFF_FFFF);
    wr(A_RISE, 32'h9);
    gpio[3] = 1'b1;
    step(3);
    wr(A_STS, 32'h8);
    rd(A_STS, 32'h8, "w1c_collide");

    // Decode
    rd(5'h1C, 32'h0, "dec_1c");
    wr(A_IN, 32'hFFFF_FFFF);
    rd(A_IN,  32'hD, "in_ro");
    rd(A_RAW, 32'hD, "raw");
    wr(A_DEB, 32'hFFFF_FFFF);
    rd(A_DEB, 32'h0000_FFFF, "deb_width");
    wr(A_DEB, 32'h0);

    // GW=8 build, no synchronizer
    sel1 = 1'b1;
    wr(A_RISE, 32'hFFFF_FFFF);
    rd(A_RISE, 32'h0000_00FF, "gw8_rise");
    gpio8 = 8'hA5;
    #1;
    rd(A_RAW, 32'h0000_00A5, "gw8_raw");
    sel1 = 1'b0;

    // Mid-run reset
    wr(A_IRQE, 32'h8);
    step(1);
    rdi(A_STS, 32'h8, 1, "pre_rst");
    #2;
    rst = 1'b1;
    rdi(A_STS, 32'h0, 0, "rst_async");
    rd(A_IN,   32'h0, "rst_in");
    rd(A_RISE, 32'h0, "rst_rise");
    rd(A_FALL, 32'h0, "rst_fall");
    rd(A_IRQE, 32'h0, "rst_irqen");
    rd(A_DEB,  32'h0, "rst_deb");
    rd(A_RAW,  32'h0, "rst_raw");
    rst = 1'b0;
    step(8);
    rdi(A_STS, 32'h0, 0, "post_rst_sts");
    rd(A_IN, 32'hD, "post_rst_in");

    step(2);
    nvec++;
    if (rd_q.size() != 0 || irq_q.size() != 0) begin
      nerr++;
      $display("FAIL drain: rd_q=%0d irq_q=%0d left, expected 0", rd_q.size(), irq_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
